// File: rtl/ringbuf_fir.sv
// FIR sequencer sitting behind the 16-entry sample ring buffer: sweeps the read
// offset over all taps, multiply-accumulates against a host coefficient bank, emits one sample.
module ringbuf_fir #(
  parameter int TAPS    = 16,
  parameter int COEFF_W = 18,
  parameter int ACC_W   = 46
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      strobe_i,
  output logic [3:0]                offset_o,
  input  logic signed [23:0]        data_i,
  output logic                      pop_o,
  input  logic                      coeff_we_i,
  input  logic [3:0]                coeff_addr_i,
  input  logic signed [COEFF_W-1:0] coeff_data_i,
  output logic signed [23:0]        data_o,
  output logic                      valid_o,
  output logic                      sat_o,
  output logic                      busy_o,
  output logic                      ovf_o
);

  localparam int DATA_W = 24;
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int FRAC   = COEFF_W - 1;
  localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 offset_q, offset_d;
  logic                       vld_p1_q, vld_p1_d;
  logic                       vld_p2_q, vld_p2_d;
  logic [3:0]                 tap_p1_q, tap_p1_d;
  logic signed [PROD_W-1:0]   prod_p2_q, prod_p2_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [COEFF_W-1:0]  coef_q [TAPS];
  logic signed [COEFF_W-1:0]  coef_d [TAPS];
  logic signed [DATA_W-1:0]   data_q, data_d;
  logic                       sat_q, sat_d;
  logic                       ovf_q, ovf_d;
  logic signed [ACC_W-1:0]    rnd;

  function automatic logic signed [ACC_W-1:0] round_half_up(input logic signed [ACC_W-1:0] a);
    return (a + RND_HALF) >>> FRAC;
  endfunction

  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] r);
    logic signed [ACC_W-1:0] c;
    c = r;
    if (r > SAT_MAX) c = SAT_MAX;
    else if (r < SAT_MIN) c = SAT_MIN;
    return c[DATA_W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [ACC_W-1:0] r);
    return (r > SAT_MAX) || (r < SAT_MIN);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // DRAIN ends once both in-flight pipeline stages have retired into the accumulator
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (strobe_i) state_d = S_RUN;
      S_RUN:   if (offset_q == LAST_TAP) state_d = S_DRAIN;
      S_DRAIN: if (!vld_p1_q && !vld_p2_q) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o   = (state_q != S_IDLE);
    valid_o  = (state_q == S_OUT);
    pop_o    = (state_q == S_OUT);
    offset_o = offset_q;
    data_o   = data_q;
    sat_o    = sat_q;
    ovf_o    = ovf_q;
  end

  always_comb begin
    offset_d = offset_q;
    case (state_q)
      S_IDLE:  offset_d = '0;
      S_RUN:   if (offset_q != LAST_TAP) offset_d = offset_q + 4'd1;
      S_OUT:   offset_d = '0;
      default: offset_d = offset_q;
    endcase

    vld_p1_d  = (state_q == S_RUN);
    tap_p1_d  = offset_q;
    vld_p2_d  = vld_p1_q;
    prod_p2_d = data_i * coef_q[tap_p1_q];

    acc_d = acc_q;
    if (state_q == S_IDLE && strobe_i) acc_d = '0;
    else if (vld_p2_q) acc_d = acc_q + {{(ACC_W-PROD_W){prod_p2_q[PROD_W-1]}}, prod_p2_q};

    rnd    = round_half_up(acc_q);
    data_d = data_q;
    sat_d  = sat_q;
    if (state_q == S_DRAIN && state_d == S_OUT) begin
      data_d = saturate(rnd);
      sat_d  = clipped(rnd);
    end

    coef_d = coef_q;
    if (coeff_we_i && state_q == S_IDLE && 32'(coeff_addr_i) < TAPS)
      coef_d[coeff_addr_i] = coeff_data_i;

    ovf_d = ovf_q | (strobe_i && state_q != S_IDLE);
  end

  // p1: ring buffer read in flight; p2: registered product; then accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      acc_q    <= '0;
      coef_q   <= '{default: '0};
      data_q   <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      offset_q <= offset_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      acc_q    <= acc_d;
      coef_q   <= coef_d;
      data_q   <= data_d;
      sat_q    <= sat_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    tap_p1_q  <= tap_p1_d;
    prod_p2_q <= prod_p2_d;
  end

endmodule

// File: tb/tb_ringbuf_fir.sv
// Scoreboard bench for ringbuf_fir: a ring-buffer model feeds samples, a reference
// dot-product model queues expected outputs, and a monitor checks every valid_o.
module tb_ringbuf_fir;

  logic               clk = 1'b0;
  logic               rst;
  logic               strobe_i;
  logic [3:0]         offset_o;
  logic signed [23:0] data_i;
  logic               pop_o;
  logic               coeff_we_i;
  logic [3:0]         coeff_addr_i;
  logic signed [17:0] coeff_data_i;
  logic signed [23:0] data_o;
  logic               valid_o, sat_o, busy_o, ovf_o;

  ringbuf_fir dut (
    .clk(clk), .rst(rst), .strobe_i(strobe_i), .offset_o(offset_o), .data_i(data_i),
    .pop_o(pop_o), .coeff_we_i(coeff_we_i), .coeff_addr_i(coeff_addr_i),
    .coeff_data_i(coeff_data_i), .data_o(data_o), .valid_o(valid_o), .sat_o(sat_o),
    .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ring buffer: index 0 = newest; one-cycle registered read
  logic signed [23:0] rb [16];
  always @(posedge clk) data_i <= rb[offset_o];

  logic signed [17:0] coef_m [16];

  typedef struct {
    logic signed [23:0] d;
    logic               s;
    int                 at;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int at);
    exp_t   e;
    longint s = 0;
    for (int k = 0; k < 16; k++) s += longint'(rb[k]) * longint'(coef_m[k]);
    s = (s + 65536) >>> 17;
    e.s = 1'b0;
    if (s > 8388607) begin s = 8388607; e.s = 1'b1; end
    else if (s < -8388608) begin s = -8388608; e.s = 1'b1; end
    e.d  = 24'(s);
    e.at = at;
    return e;
  endfunction

  always @(negedge clk) begin
    if (valid_o || pop_o) begin
      chk("pop_with_valid", longint'(pop_o), longint'(valid_o));
      if (pop_o) n_pop++;
    end
    if (valid_o) begin
      n_valid++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: data_o=%0d appeared with no request pending", data_o);
      end else begin
        mon_e = q.pop_front();
        chk("data_o", longint'(data_o), longint'(mon_e.d));
        chk("sat_o", longint'(sat_o), longint'(mon_e.s));
        chk("latency", longint'(cyc), longint'(mon_e.at));
      end
    end
  end

  task automatic wcoef(input int a, input logic signed [17:0] v);
    @(negedge clk);
    coeff_we_i = 1'b1; coeff_addr_i = 4'(a); coeff_data_i = v;
    @(negedge clk);
    coeff_we_i = 1'b0;
    coef_m[a] = v;
  endtask

  task automatic all_coefs(input logic signed [17:0] v);
    for (int i = 0; i < 16; i++) wcoef(i, v);
  endtask

  task automatic fill(input logic signed [23:0] v);
    for (int i = 0; i < 16; i++) rb[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) rb[i] = 24'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy_o; i++) @(negedge clk);
    chk("busy_done", longint'(busy_o), 0);
    chk("offset_idle", longint'(offset_o), 0);
  endtask

  task automatic run(input bit sweep);
    @(negedge clk);
    strobe_i = 1'b1;
    q.push_back(model(cyc + 20));
    @(negedge clk);
    strobe_i = 1'b0;
    if (sweep) begin
      chk("busy_start", longint'(busy_o), 1);
      for (int k = 0; k < 16; k++) begin
        chk("offset_sweep", longint'(offset_o), longint'(k));
        if (k < 15) @(negedge clk);
      end
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nv, np;
    rst = 1'b1; strobe_i = 1'b0; coeff_we_i = 1'b0; coeff_addr_i = '0; coeff_data_i = '0;
    fill(24'sd0);
    for (int i = 0; i < 16; i++) coef_m[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_offset", longint'(offset_o), 0);
    chk("rst_pop", longint'(pop_o), 0);
    chk("rst_data", longint'(data_o), 0);
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_sat", longint'(sat_o), 0);
    chk("rst_busy", longint'(busy_o), 0);
    chk("rst_ovf", longint'(ovf_o), 0);
    rst = 1'b0;

    fill_rand();
    run(1);

    wcoef(0, 18'sh10000);
    fill_rand(); rb[0] = 24'sd1000; run(1);
    fill_rand(); rb[0] = 24'sd3;    run(1);
    fill_rand(); rb[0] = -24'sd3;   run(1);

    all_coefs(18'sh02000);
    fill(24'sh100000); run(0);

    all_coefs(18'sh1FFFF);
    fill(24'sh7FFFFF); run(0);
    fill(24'sh800000); run(0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (r < 2) wcoef(i, 18'($urandom));
        else       wcoef(i, 18'($signed(18'($urandom)) >>> 4));
      end
      fill_rand();
      run(r == 0);
    end

    all_coefs(18'sd0);
    wcoef(0, 18'sh10000);
    fill_rand(); rb[0] = 24'sd1000;
    nv = n_valid; np = n_pop;
    @(negedge clk);
    strobe_i = 1'b1;
    q.push_back(model(cyc + 20));
    @(negedge clk);
    strobe_i = 1'b0;
    repeat (4) @(negedge clk);
    strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    coeff_we_i = 1'b1; coeff_addr_i = 4'd0; coeff_data_i = 18'sh1FFFF;
    @(negedge clk);
    coeff_we_i = 1'b0;
    chk("ovf_set", longint'(ovf_o), 1);
    wait_idle();
    chk("one_valid", longint'(n_valid - nv), 1);
    chk("one_pop", longint'(n_pop - np), 1);
    fill_rand(); rb[0] = 24'sd1000;
    run(0);
    chk("ovf_sticky", longint'(ovf_o), 1);

    fill_rand();
    nv = n_valid;
    @(negedge clk);
    strobe_i = 1'b1;
    @(negedge clk);
    strobe_i = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) coef_m[i] = '0;
    chk("midrst_busy", longint'(busy_o), 0);
    chk("midrst_valid", longint'(valid_o), 0);
    chk("midrst_pop", longint'(pop_o), 0);
    chk("midrst_ovf", longint'(ovf_o), 0);
    repeat (30) @(negedge clk);
    chk("midrst_no_valid", longint'(n_valid - nv), 0);
    for (int i = 0; i < 16; i++) rb[i] = 24'sh400000 + 24'(i);
    run(1);

    repeat (3) @(negedge clk);
    chk("queue_empty", longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
